// File: rtl/servo_pkg.sv
// servo_pkg: shared constants, state encoding and pulse type for the servo
// motion controller.
//   CLK_FREQ, FRAME_CLK, PULSE_MIN, PULSE_MAX, PARK_PULSE : default timing
//   W        : width of every pulse and counter value
//   pulse_t  : pulse-width / counter type
//   state_t  : sequencer state encoding
//   clamp_pulse() : saturate a value into [lo, hi]
package servo_pkg;
  localparam int CLK_FREQ   = 30_000_000;
  localparam int W          = 20;
  localparam int FRAME_CLK  = 600_000;
  localparam int PULSE_MIN  = 30_000;
  localparam int PULSE_MAX  = 60_000;
  localparam int PARK_PULSE = 45_000;

  typedef logic [W-1:0] pulse_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  function automatic pulse_t clamp_pulse(input pulse_t p, input pulse_t lo,
                                         input pulse_t hi);
    if (p < lo)      return lo;
    else if (p > hi) return hi;
    else             return p;
  endfunction
endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: free-running frame counter.
//   clk_30MHz, rst_n : clock, async active-low reset
//   tick        : count == FRAME_CLK-1 (last cycle of a frame)
//   frame_start : registered tick, high while count == 0
//   count       : current position inside the frame
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int FRAME_CLK = servo_pkg::FRAME_CLK
) (
  input  logic   clk_30MHz,
  input  logic   rst_n,
  output logic   tick,
  output logic   frame_start,
  output pulse_t count
);
  assign tick = (count == pulse_t'(FRAME_CLK - 1));

  always_ff @(posedge clk_30MHz or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      frame_start <= 1'b0;
    end else begin
      count       <= tick ? '0 : count + pulse_t'(1);
      frame_start <= tick;
    end
  end
endmodule

// File: rtl/servo_motion_ctrl.sv
// servo_motion_ctrl: accepts pulse-width targets, clamps them to the legal
// servo range and slews pulse_width toward them by at most STEP per frame,
// then holds for HOLD_FRAMES frames before reporting done.
//   clk_30MHz, rst_n     : clock, async active-low reset
//   cmd_valid/cmd_ready  : command handshake, cmd_pulse = requested width
//   abort                : freeze motion at the current width (RAMP only)
//   pulse_width          : width consumed by the PWM stage, changes only
//                          together with frame_start
//   frame_start          : one-cycle frame strobe
//   busy / done / clamped: status (done, clamped are one-cycle strobes)
// Optional: define SERVO_PWM_OUT_EN to add servo_pwm, a direct PWM output.
module servo_motion_ctrl
  import servo_pkg::*;
#(
  parameter int FRAME_CLK   = servo_pkg::FRAME_CLK,
  parameter int PULSE_MIN   = servo_pkg::PULSE_MIN,
  parameter int PULSE_MAX   = servo_pkg::PULSE_MAX,
  parameter int PARK_PULSE  = servo_pkg::PARK_PULSE,
  parameter int STEP        = 300,
  parameter int HOLD_FRAMES = 25
) (
  input  logic   clk_30MHz,
  input  logic   rst_n,
  input  logic   cmd_valid,
  output logic   cmd_ready,
  input  pulse_t cmd_pulse,
  input  logic   abort,
  output pulse_t pulse_width,
  output logic   frame_start,
  output logic   busy,
  output logic   done,
`ifdef SERVO_PWM_OUT_EN
  output logic   servo_pwm,
`endif
  output logic   clamped
);
  localparam pulse_t     P_MIN  = pulse_t'(PULSE_MIN);
  localparam pulse_t     P_MAX  = pulse_t'(PULSE_MAX);
  localparam pulse_t     P_PARK = pulse_t'(PARK_PULSE);
  localparam pulse_t     HOLD_W = pulse_t'(HOLD_FRAMES);
  localparam logic [W:0] STEP_W = (W+1)'(STEP);

  state_t   state;
  pulse_t   target, settle_cnt, frame_cnt, cmd_clamped, step_next;
  logic     tick;
  logic     out_of_range;
  logic signed [W:0] diff;
  logic [W:0] mag, step_amt;

  servo_frame_timer #(.FRAME_CLK(FRAME_CLK)) u_timer (
    .clk_30MHz  (clk_30MHz),
    .rst_n      (rst_n),
    .tick       (tick),
    .frame_start(frame_start),
    .count      (frame_cnt)
  );

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign cmd_clamped  = clamp_pulse(cmd_pulse, P_MIN, P_MAX);
  assign out_of_range = (cmd_pulse < P_MIN) || (cmd_pulse > P_MAX);

  // One slew step: move by min(STEP, |target - pulse_width|) toward target.
  always_comb begin
    diff      = $signed({1'b0, target}) - $signed({1'b0, pulse_width});
    mag       = diff[W] ? unsigned'(-diff) : unsigned'(diff);
    step_amt  = (mag > STEP_W) ? STEP_W : mag;
    step_next = diff[W] ? pulse_width - step_amt[W-1:0]
                        : pulse_width + step_amt[W-1:0];
  end

  always_ff @(posedge clk_30MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pulse_width <= P_PARK;
      target      <= P_PARK;
      settle_cnt  <= '0;
      done        <= 1'b0;
      clamped     <= 1'b0;
    end else begin
      done    <= 1'b0;
      clamped <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          target     <= cmd_clamped;
          clamped    <= out_of_range;
          settle_cnt <= HOLD_W;
          state      <= (cmd_clamped != pulse_width) ? RAMP : SETTLE;
        end
        RAMP: begin
          // abort beats a coincident tick: freeze without stepping
          if (abort) begin
            target     <= pulse_width;
            settle_cnt <= HOLD_W;
            state      <= SETTLE;
          end else if (tick) begin
            pulse_width <= step_next;
            if (step_next == target) begin
              settle_cnt <= HOLD_W;
              state      <= SETTLE;
            end
          end
        end
        SETTLE: if (tick) begin
          settle_cnt <= settle_cnt - pulse_t'(1);
          if (settle_cnt == pulse_t'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERVO_PWM_OUT_EN
  always_ff @(posedge clk_30MHz or negedge rst_n) begin
    if (!rst_n) servo_pwm <= 1'b0;
    else        servo_pwm <= (frame_cnt < pulse_width);
  end
`else
  logic unused_frame_cnt;
  assign unused_frame_cnt = ^frame_cnt;
`endif
endmodule

// File: tb/tb_servo_motion_ctrl.sv
// tb_servo_motion_ctrl: directed plus randomized checks of servo_motion_ctrl
// against a frame-level reference model (target clamp, per-frame slew,
// hold count). Runs with FRAME_CLK=100, STEP=3000, HOLD_FRAMES=2.
module tb_servo_motion_ctrl;
  localparam int FC   = 100;
  localparam int ST   = 3000;
  localparam int HF   = 2;
  localparam int PMIN = 30000;
  localparam int PMAX = 60000;
  localparam int PARK = 45000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, abort;
  logic [19:0] cmd_pulse, pulse_width;
  logic        frame_start, busy, done, clamped;
`ifdef SERVO_PWM_OUT_EN
  logic        servo_pwm;
`endif

  int checks = 0;
  int errors = 0;
  int model_pw;

  always #5 clk = ~clk;

  servo_motion_ctrl #(.FRAME_CLK(FC), .STEP(ST), .HOLD_FRAMES(HF)) dut (
    .clk_30MHz  (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_pulse  (cmd_pulse),
    .abort      (abort),
    .pulse_width(pulse_width),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done),
`ifdef SERVO_PWM_OUT_EN
    .servo_pwm  (servo_pwm),
`endif
    .clamped    (clamped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance at least one cycle, stop at the next frame_start (bounded).
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 2*FC);
    chk("frame_start_seen", {31'b0, frame_start}, 1);
  endtask

  function automatic int clampv(input int v);
    return (v < PMIN) ? PMIN : (v > PMAX) ? PMAX : v;
  endfunction

  function automatic int slew(input int cur, input int tgt);
    int d = tgt - cur;
    if (d > ST)  return cur + ST;
    if (d < -ST) return cur - ST;
    return tgt;
  endfunction

  // Reset check then release; first frame_start must land exactly FC cycles later.
  task automatic reset_and_release(input string tag);
    int k = 0;
    rst_n = 1'b0;
    #1;
    chk({tag, "_pw"}, {12'b0, pulse_width}, PARK);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_ready"}, {31'b0, cmd_ready}, 1);
    chk({tag, "_fs"}, {31'b0, frame_start}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_clamped"}, {31'b0, clamped}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (frame_start !== 1'b1 && k < 3*FC);
    chk({tag, "_first_fs_cycle"}, k, FC);
    chk({tag, "_pw_after"}, {12'b0, pulse_width}, PARK);
    model_pw = PARK;
  endtask

  // Issue one command; abort_after>=1 aborts after that many steps
  // (on_tick: abort lands in the same cycle as the frame tick).
  task automatic run_cmd(input int val, input int abort_after, input bit on_tick);
    int tgt, cur, steps, n;
    tgt = clampv(val);
    cur = model_pw;
    steps = 0;
    n = 0;
    repeat ($urandom_range(0, 120)) @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 4*FC) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_cmd", {31'b0, cmd_ready}, 1);
    cmd_pulse = val[19:0];
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("clamped", {31'b0, clamped}, (val < PMIN || val > PMAX) ? 1 : 0);
    chk("busy_after_accept", {31'b0, busy}, 1);
    chk("ready_after_accept", {31'b0, cmd_ready}, 0);
    @(negedge clk);
    chk("clamped_one_cycle", {31'b0, clamped}, 0);
    while (cur != tgt) begin
      if (steps >= 1 && steps == abort_after) begin
        if (on_tick) repeat (FC - 1) @(negedge clk);
        else         repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("pw_after_abort", {12'b0, pulse_width}, cur);
        if (on_tick) chk("abort_tick_coincide", {31'b0, frame_start}, 1);
        tgt = cur;
        break;
      end
      wait_fs();
      cur = slew(cur, tgt);
      steps++;
      chk("pw_step", {12'b0, pulse_width}, cur);
    end
    for (int h = 1; h <= HF; h++) begin
      wait_fs();
      chk("pw_hold", {12'b0, pulse_width}, cur);
      chk("done_at_hold", {31'b0, done}, (h == HF) ? 1 : 0);
      chk("busy_at_hold", {31'b0, busy}, (h == HF) ? 0 : 1);
    end
    chk("ready_after_done", {31'b0, cmd_ready}, 1);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 0);
    model_pw = cur;
  endtask

  initial begin
    int v, t, nst, ab;
    cmd_valid = 1'b0;
    cmd_pulse = '0;
    abort     = 1'b0;
    rst_n     = 1'b0;
    model_pw  = PARK;
    @(negedge clk);
    reset_and_release("reset");

    run_cmd(54000, -1, 1'b0);   // 48000, 51000, 54000
    run_cmd(10000, -1, 1'b0);   // clamps to 30000
    run_cmd(45000, -1, 1'b0);
    run_cmd(46000, -1, 1'b0);   // single partial step
    run_cmd(46000, -1, 1'b0);   // already there: straight to hold

    reset_and_release("reset2");
    run_cmd(60000, 2, 1'b0);    // abort while at 51000
    run_cmd(30000, 1, 1'b1);    // abort coincident with the tick
    run_cmd(70000, -1, 1'b0);   // clamps to 60000

    for (int i = 0; i < 8; i++) begin
      v   = $urandom_range(0, 70000);
      t   = clampv(v);
      nst = ((t > model_pw ? t - model_pw : model_pw - t) + ST - 1) / ST;
      ab  = (nst >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, nst - 1) : -1;
      run_cmd(v, ab, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a ramp.
    cmd_pulse = (model_pw >= PARK) ? 20'd30000 : 20'd60000;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("midramp_busy", {31'b0, busy}, 1);
    wait_fs();
    repeat ($urandom_range(1, 90)) @(negedge clk);
    reset_and_release("midramp_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
